// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: default parameters, FSM
// state encoding, exception type codes, stage indices and stall levels.
package pipe_ctrl_pkg;

  // Default configuration of the MIPS core pipeline
  localparam int unsigned NUM_STAGES_DEF = 6;
  localparam int unsigned PC_W_DEF       = 32;
  localparam int unsigned CNT_W_DEF      = 6;
  localparam logic [31:0] EXC_VEC_DEF    = 32'h0000_0020;

  // Stage indices (stall bit positions)
  localparam int unsigned STG_PC  = 0;
  localparam int unsigned STG_IF  = 1;
  localparam int unsigned STG_ID  = 2;
  localparam int unsigned STG_EX  = 3;
  localparam int unsigned STG_MEM = 4;
  localparam int unsigned STG_WB  = 5;

  // Per-stage stall levels
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Controller FSM
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Exception kinds; codes 2 and 3 are reserved and behave like EXCP_EXC
  typedef enum logic [1:0] {
    EXCP_EXC  = 2'd0,
    EXCP_ERET = 2'd1
  } excp_e;

endpackage

// File: rtl/pipe_ctrl_hold_timer.sv
// Self-timed multi-cycle stall hold for fixed-latency units.
// Ports:
//   clk, rst       clock, async active-low reset
//   load_i         load len_i / stage_i into the timer
//   clear_i        abandon any running hold (wins over load_i)
//   len_i          hold length in cycles
//   stage_i        stage to hold, clamped to the last stage
//   active_o       hold counter nonzero
//   mask_o         one-hot request for the held stage while active
module pipe_ctrl_hold_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES = NUM_STAGES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  localparam int unsigned SW        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic [CNT_W-1:0]      len_i,
  input  logic [SW-1:0]         stage_i,
  output logic                  active_o,
  output logic [NUM_STAGES-1:0] mask_o
);

  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [SW-1:0]    stage_clamped;

  // Out-of-range stage indices fall back to the last stage
  always_comb begin
    stage_clamped = (stage_i > LAST_STAGE) ? LAST_STAGE : stage_i;
  end

  // Counter / stage latch next state
  always_comb begin
    cnt_d   = cnt_q;
    stage_d = stage_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d   = len_i;
      stage_d = stage_clamped;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      stage_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
    end
  end

  assign active_o = (cnt_q != '0);

  // One-hot request for the latched stage
  always_comb begin
    mask_o = '0;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      mask_o[i] = active_o && (stage_q == SW'(i));
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges per-stage stall requests and a timed hold
// into a prefix stall vector, and sequences exception/ERET flushes with the
// redirect PC.
// Ports:
//   clk, rst        clock, async active-low reset
//   stallreq        per-stage stall requests (combinational)
//   hold_start      pulse: start a timed hold of hold_len cycles on hold_stage
//   excp_valid      exception/ERET committed this cycle; excp_type selects
//                   EXC_VEC (0,2,3) or cp0_epc (1)
//   stall           per-stage hold, stages 0..k where k is the top request
//   flush           one-cycle clear of all pipeline registers
//   new_pc          redirect target, valid while flush=1
//   hold_active     timed hold running
//   busy            controller not in RUN
// Optional (macro PIPE_CTRL_PERF_EN): stall_cycles and flush_count
// saturating performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES = NUM_STAGES_DEF,
  parameter int unsigned PC_W       = PC_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter logic [PC_W-1:0] EXC_VEC = PC_W'(EXC_VEC_DEF),
  localparam int unsigned SW        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stallreq,
  input  logic                  hold_start,
  input  logic [SW-1:0]         hold_stage,
  input  logic [CNT_W-1:0]      hold_len,
  input  logic                  excp_valid,
  input  logic [1:0]            excp_type,
  input  logic [PC_W-1:0]       cp0_epc,
  output logic [NUM_STAGES-1:0] stall,
  output logic                  flush,
  output logic [PC_W-1:0]       new_pc,
  output logic                  hold_active,
  output logic                  busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [15:0]           flush_count
`endif
);

  state_e                state_q, state_d;
  logic [PC_W-1:0]       new_pc_q, new_pc_d;
  logic                  hold_load;
  logic                  hold_clear;
  logic                  freeze;
  logic [NUM_STAGES-1:0] hold_mask;
  logic [NUM_STAGES-1:0] eff;
  logic [NUM_STAGES-1:0] prio;
  logic                  any_above;

  pipe_ctrl_hold_timer #(
    .NUM_STAGES (NUM_STAGES),
    .CNT_W      (CNT_W)
  ) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (hold_load),
    .clear_i  (hold_clear),
    .len_i    (hold_len),
    .stage_i  (hold_stage),
    .active_o (hold_active),
    .mask_o   (hold_mask)
  );

  // FSM next state, redirect capture and hold control
  always_comb begin
    state_d    = state_q;
    new_pc_d   = new_pc_q;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    freeze     = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (excp_valid) begin
          // Exception wins over a simultaneous hold_start and kills any hold
          freeze     = 1'b1;
          hold_clear = 1'b1;
          new_pc_d   = (excp_type == 2'(EXCP_ERET)) ? cp0_epc : EXC_VEC;
          state_d    = ST_FLUSH;
        end else if (hold_start && !hold_active && (hold_len != '0)) begin
          hold_load = 1'b1;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      new_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      new_pc_q <= new_pc_d;
    end
  end

  assign eff = stallreq | hold_mask;

  // Prefix priority encoder: every stage at or below the top request stalls
  always_comb begin
    any_above = NO_STOP;
    prio      = '0;
    for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
      any_above = any_above | eff[i];
      prio[i]   = any_above;
    end
  end

  // Stall is zero-latency; forced low in reset and during the flush cycle
  always_comb begin
    stall = '0;
    if (rst && (state_q == ST_RUN)) begin
      stall = freeze ? {NUM_STAGES{STOP}} : prio;
    end
  end

  assign flush  = (state_q == ST_FLUSH);
  assign busy   = (state_q != ST_RUN);
  assign new_pc = new_pc_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  // Saturating event counters
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if ((stall != '0) && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'(1);
    end
    if (flush && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + 16'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-cycle stimulus tables, expected
// output words queued on drive and compared at the falling edge.
module tb_pipe_ctrl;

  localparam int unsigned NS  = 6;
  localparam int unsigned PCW = 32;
  localparam int unsigned CW  = 6;
  localparam int unsigned SW  = 3;

  typedef logic [NS+PCW+2:0] obs_t;  // {stall, flush, new_pc, hold_active, busy}

  typedef struct packed {
    logic          rst;
    logic [NS-1:0] sr;
    logic          hs;
    logic [SW-1:0] hst;
    logic [CW-1:0] hl;
    logic          ev;
    logic [1:0]    et;
    logic [PCW-1:0] epc;
    obs_t          exp;
  } vec_t;

  logic           clk;
  logic           rst;
  logic [NS-1:0]  stallreq;
  logic           hold_start;
  logic [SW-1:0]  hold_stage;
  logic [CW-1:0]  hold_len;
  logic           excp_valid;
  logic [1:0]     excp_type;
  logic [PCW-1:0] cp0_epc;
  logic [NS-1:0]  stall;
  logic           flush;
  logic [PCW-1:0] new_pc;
  logic           hold_active;
  logic           busy;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]    stall_cycles;
  logic [15:0]    flush_count;
`endif

  int   vectors;
  int   miscompares;
  obs_t sb[$];
  vec_t tbl[$];
  obs_t got;
  obs_t want;

  pipe_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq    (stallreq),
    .hold_start  (hold_start),
    .hold_stage  (hold_stage),
    .hold_len    (hold_len),
    .excp_valid  (excp_valid),
    .excp_type   (excp_type),
    .cp0_epc     (cp0_epc),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .hold_active (hold_active),
    .busy        (busy)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t observe();
    return {stall, flush, new_pc, hold_active, busy};
  endfunction

  function automatic vec_t mkv(input logic r, input logic [NS-1:0] sr, input logic hs,
                               input logic [SW-1:0] hst, input logic [CW-1:0] hl,
                               input logic ev, input logic [1:0] et, input logic [PCW-1:0] epc,
                               input logic [NS-1:0] e_stall, input logic e_flush,
                               input logic [PCW-1:0] e_pc, input logic e_ha, input logic e_busy);
    vec_t v;
    v.rst = r; v.sr = sr; v.hs = hs; v.hst = hst; v.hl = hl;
    v.ev = ev; v.et = et; v.epc = epc;
    v.exp = {e_stall, e_flush, e_pc, e_ha, e_busy};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst        = v.rst;
    stallreq   = v.sr;
    hold_start = v.hs;
    hold_stage = v.hst;
    hold_len   = v.hl;
    excp_valid = v.ev;
    excp_type  = v.et;
    cp0_epc    = v.epc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tbl.delete();
    // rst low with every input busy: outputs must stay quiet
    tbl.push_back(mkv(0, 6'b111111, 1, 3'd3, 6'd4, 1, 2'd1, 32'hffff_ffff, 6'b000000, 0, 32'h0, 0, 0));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0,         6'b000000, 0, 32'h0, 0, 0));
    tick();
    foreach (tbl[i]) begin
      drive(tbl[i]);
      sb.push_back(tbl[i].exp);
      @(negedge clk);
      got  = observe();
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL reset[%0d]: got %h want %h", i, got, want);
      end
      tick();
    end
  endtask

  task automatic test_stall_merge();
    tbl.delete();
    tbl.push_back(mkv(1, 6'b000100, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0, 6'b000111, 0, 32'h0, 0, 0));
    tbl.push_back(mkv(1, 6'b001100, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0, 6'b001111, 0, 32'h0, 0, 0));
    tbl.push_back(mkv(1, 6'b100000, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0, 6'b111111, 0, 32'h0, 0, 0));
    tbl.push_back(mkv(1, 6'b000001, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0, 6'b000001, 0, 32'h0, 0, 0));
    tbl.push_back(mkv(1, 6'b010010, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0, 6'b011111, 0, 32'h0, 0, 0));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0, 6'b000000, 0, 32'h0, 0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      sb.push_back(tbl[i].exp);
      @(negedge clk);
      got  = observe();
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL stall_merge[%0d]: got %h want %h", i, got, want);
      end
      tick();
    end
  endtask

  task automatic test_hold();
    tbl.delete();
    // hold on EX for 4 cycles; requester stalls itself in the start cycle
    tbl.push_back(mkv(1, 6'b001000, 1, 3'd3, 6'd4, 0, 2'd0, 32'h0, 6'b001111, 0, 32'h0, 0, 0));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0, 6'b001111, 0, 32'h0, 1, 0));
    // second start while active is ignored
    tbl.push_back(mkv(1, 6'b000000, 1, 3'd5, 6'd3, 0, 2'd0, 32'h0, 6'b001111, 0, 32'h0, 1, 0));
    tbl.push_back(mkv(1, 6'b010000, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0, 6'b011111, 0, 32'h0, 1, 0));
    tbl.push_back(mkv(1, 6'b000010, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0, 6'b001111, 0, 32'h0, 1, 0));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0, 6'b000000, 0, 32'h0, 0, 0));
    // out-of-range stage clamps to WB
    tbl.push_back(mkv(1, 6'b000000, 1, 3'd7, 6'd1, 0, 2'd0, 32'h0, 6'b000000, 0, 32'h0, 0, 0));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0, 6'b111111, 0, 32'h0, 1, 0));
    // zero length is ignored
    tbl.push_back(mkv(1, 6'b000000, 1, 3'd2, 6'd0, 0, 2'd0, 32'h0, 6'b000000, 0, 32'h0, 0, 0));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0, 6'b000000, 0, 32'h0, 0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      sb.push_back(tbl[i].exp);
      @(negedge clk);
      got  = observe();
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL hold[%0d]: got %h want %h", i, got, want);
      end
      tick();
    end
  endtask

  task automatic test_exception();
    tbl.delete();
    tbl.push_back(mkv(1, 6'b000001, 0, 3'd0, 6'd0, 1, 2'd0, 32'h0,         6'b111111, 0, 32'h0,         0, 0));
    // inputs ignored during FLUSH
    tbl.push_back(mkv(1, 6'b111111, 1, 3'd2, 6'd5, 1, 2'd1, 32'hdead_beef, 6'b000000, 1, 32'h20,        0, 1));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0,         6'b000000, 0, 32'h20,        0, 0));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0, 1, 2'd1, 32'h8000_0100, 6'b111111, 0, 32'h20,        0, 0));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0,         6'b000000, 1, 32'h8000_0100, 0, 1));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0,         6'b000000, 0, 32'h8000_0100, 0, 0));
    // reserved type behaves as exception
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0, 1, 2'd2, 32'h1234,      6'b111111, 0, 32'h8000_0100, 0, 0));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0,         6'b000000, 1, 32'h20,        0, 1));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0,         6'b000000, 0, 32'h20,        0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      sb.push_back(tbl[i].exp);
      @(negedge clk);
      got  = observe();
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL exception[%0d]: got %h want %h", i, got, want);
      end
      tick();
    end
  endtask

  task automatic test_excp_in_hold();
    tbl.delete();
    tbl.push_back(mkv(1, 6'b000000, 1, 3'd4, 6'd10, 0, 2'd0, 32'h0,   6'b000000, 0, 32'h20,  0, 0));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0,  0, 2'd0, 32'h0,   6'b011111, 0, 32'h20,  1, 0));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0,  0, 2'd0, 32'h0,   6'b011111, 0, 32'h20,  1, 0));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0,  1, 2'd1, 32'h400, 6'b111111, 0, 32'h20,  1, 0));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0,  0, 2'd0, 32'h0,   6'b000000, 1, 32'h400, 0, 1));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0,  0, 2'd0, 32'h0,   6'b000000, 0, 32'h400, 0, 0));
    // simultaneous start and exception: no hold loaded
    tbl.push_back(mkv(1, 6'b000000, 1, 3'd2, 6'd3,  1, 2'd0, 32'h0,   6'b111111, 0, 32'h400, 0, 0));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0,  0, 2'd0, 32'h0,   6'b000000, 1, 32'h20,  0, 1));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0,  0, 2'd0, 32'h0,   6'b000000, 0, 32'h20,  0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      sb.push_back(tbl[i].exp);
      @(negedge clk);
      got  = observe();
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL excp_in_hold[%0d]: got %h want %h", i, got, want);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    tbl.delete();
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0, 1, 2'd0, 32'h0,   6'b111111, 0, 32'h20,  0, 0));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0,   6'b000000, 1, 32'h20,  0, 1));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0, 1, 2'd1, 32'h500, 6'b111111, 0, 32'h20,  0, 0));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0,   6'b000000, 1, 32'h500, 0, 1));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0,   6'b000000, 0, 32'h500, 0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      sb.push_back(tbl[i].exp);
      @(negedge clk);
      got  = observe();
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got %h want %h", i, got, want);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    tbl.delete();
    tbl.push_back(mkv(1, 6'b000000, 1, 3'd2, 6'd10, 0, 2'd0, 32'h0, 6'b000000, 0, 32'h500, 0, 0));
    // reset mid-hold, with requests present
    tbl.push_back(mkv(0, 6'b111111, 0, 3'd0, 6'd0,  0, 2'd0, 32'h0, 6'b000000, 0, 32'h0,   0, 0));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0,  0, 2'd0, 32'h0, 6'b000000, 0, 32'h0,   0, 0));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0,  1, 2'd1, 32'h77, 6'b111111, 0, 32'h0,  0, 0));
    // reset during FLUSH
    tbl.push_back(mkv(0, 6'b000000, 0, 3'd0, 6'd0,  0, 2'd0, 32'h0, 6'b000000, 0, 32'h0,   0, 0));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0,  0, 2'd0, 32'h0, 6'b000000, 0, 32'h0,   0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      sb.push_back(tbl[i].exp);
      @(negedge clk);
      got  = observe();
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL reset_mid[%0d]: got %h want %h", i, got, want);
      end
      tick();
    end
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic test_perf();
    tbl.delete();
    tbl.push_back(mkv(0, 6'b000000, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0, 6'b000000, 0, 32'h0,  0, 0));
    for (int k = 0; k < 5; k++) begin
      tbl.push_back(mkv(1, 6'b000001, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0, 6'b000001, 0, 32'h0, 0, 0));
    end
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0, 1, 2'd0, 32'h0, 6'b111111, 0, 32'h0,  0, 0));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0, 6'b000000, 1, 32'h20, 0, 1));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0, 1, 2'd0, 32'h0, 6'b111111, 0, 32'h20, 0, 0));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0, 6'b000000, 1, 32'h20, 0, 1));
    tbl.push_back(mkv(1, 6'b000000, 0, 3'd0, 6'd0, 0, 2'd0, 32'h0, 6'b000000, 0, 32'h20, 0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      sb.push_back(tbl[i].exp);
      @(negedge clk);
      got  = observe();
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL perf_seq[%0d]: got %h want %h", i, got, want);
      end
      tick();
    end
    @(negedge clk);
    vectors++;
    if (stall_cycles !== 32'd7) begin
      miscompares++;
      $display("FAIL stall_cycles: got %0d want 7", stall_cycles);
    end
    vectors++;
    if (flush_count !== 16'd2) begin
      miscompares++;
      $display("FAIL flush_count: got %0d want 2", flush_count);
    end
    tick();
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    stallreq    = '0;
    hold_start  = 1'b0;
    hold_stage  = '0;
    hold_len    = '0;
    excp_valid  = 1'b0;
    excp_type   = '0;
    cp0_epc     = '0;
    test_reset();
    test_stall_merge();
    test_hold();
    test_exception();
    test_excp_in_hold();
    test_back_to_back();
    test_reset_mid();
`ifdef PIPE_CTRL_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised pipeline controller for the MIPS core; successor to the single-request stall controller.
- Merges per-stage stall requests, including a self-timed multi-cycle hold for fixed-latency units such as the divider.
- Sequences exception/ERET flushes and supplies the redirect PC.
- Sits beside the datapath; drives stall/flush into every pipeline register and new_pc into the PC stage.

Parameters:
- NUM_STAGES, 6, pipeline stages; index 0=pc, 1=if, 2=id, 3=ex, 4=mem, 5=wb
- PC_W, 32, PC width
- CNT_W, 6, hold length counter width
- EXC_VEC, 32'h0000_0020, exception entry address

Ports:
- clk  in  1  clock; rising edge
- rst  in  1  asynchronous, active-low reset
- stallreq  in  NUM_STAGES  bit i = stage i requests a stall this cycle (combinational)
- hold_start  in  1  one-cycle pulse: start a timed hold
- hold_stage  in  $clog2(NUM_STAGES)  stage the timed hold applies to
- hold_len  in  CNT_W  number of hold cycles
- excp_valid  in  1  exception/ERET committed this cycle
- excp_type  in  2  0=exception → EXC_VEC, 1=ERET → cp0_epc, 2/3 reserved (treated as 0)
- cp0_epc  in  PC_W  EPC value
- stall  out  NUM_STAGES  bit i = stage i holds
- flush  out  1  clear all pipeline registers
- new_pc  out  PC_W  redirect target; valid while flush=1
- hold_active  out  1  timed hold counter nonzero
- busy  out  1  FSM not in RUN

Behaviour:
- Reset (rst=0, async): state=RUN, hold counter=0, hold stage=0, new_pc=0. Outputs while in reset: flush=0, stall=0, hold_active=0, busy=0. Reset mid-hold or mid-flush abandons that operation.
- Effective request: eff = stallreq | (hold_active ? onehot(hold_stage_q) : 0).
- Stall vector (combinational, zero latency):
  - k = highest set bit of eff; stall = bits [k:0] all set.
  - eff=0 → stall=0.
  - Example: request from id only (NUM_STAGES=6) gives 6'b000111.
  - Stage k+1 sees a bubble; the pipeline registers insert it.
- FSM, 2 states:
  - RUN: excp_valid=1 → stall=all ones this cycle (freeze). Register new_pc = (excp_type==1) ? cp0_epc : EXC_VEC. Next state FLUSH.
  - FLUSH: flush=1, stall=0, busy=1 for exactly one cycle. excp_valid, hold_start and stallreq are ignored. Next state RUN.
  - flush=0 in RUN. new_pc holds its last value between flushes.
- Timed hold:
  - hold_start=1 in RUN with hold_active=0, hold_len≠0 and no excp_valid → counter=hold_len, hold_stage_q=hold_stage (clamped to NUM_STAGES-1).
  - Hold applies in cycles t+1..t+hold_len. Counter decrements every cycle while nonzero.
  - The requester asserts stallreq itself in cycle t.
  - hold_start while hold_active=1: ignored. hold_len=0: ignored.
  - excp_valid clears the counter in the same edge and takes priority over a simultaneous hold_start.
- Overlap: stallreq during a hold → the higher stage index determines stall. Counter runs independently of stallreq.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - Adds output stall_cycles[31:0]: counts cycles with stall≠0.
  - Adds output flush_count[15:0]: counts flush pulses.
  - Both counters saturate and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared defines/package:
  - FSM state encodings RUN/FLUSH.
  - excp_type codes EXC/ERET.
  - EXC_VEC default.
  - Stage index constants PC/IF/ID/EX/MEM/WB.
  - Stop/NoStop levels.
- Sub-module pipe_ctrl_hold_timer: counter, stage latch and hold_active. Inputs: load, clear, len, stage. Output: stage mask.
- The FSM and stall priority encoder stay in pipe_ctrl.

Test Plan:
- Reset released, all inputs 0 → stall=000000, flush=0, new_pc=0, busy=0.
- stallreq=000100 → stall=000111 same cycle. stallreq=001100 → stall=001111. stallreq=100000 → stall=111111.
- hold_start, hold_stage=3, hold_len=4 at cycle t → stall=001111 for cycles t+1..t+4 with stallreq=0; hold_active drops at t+5. A second hold_start at t+2 is ignored.
- excp_valid, excp_type=0 at t → stall=111111 at t; flush=1 at t+1 with new_pc=0x20; RUN at t+2. Repeat with excp_type=1, cp0_epc=0x8000_0100 → new_pc=0x8000_0100.
- excp_valid during an active hold (hold_len=10, at cycle 3) → counter cleared; after the flush, stall=000000 with stallreq=0. Simultaneous hold_start and excp_valid → no hold loaded.
- Reset asserted mid-hold and during FLUSH → all outputs 0 immediately. With PIPE_CTRL_PERF_EN: 7 stalled cycles and 2 flushes → stall_cycles=7, flush_count=2.
